// File: rtl/cpu_pkg.sv
// Shared definitions for the program loader and its instruction memory.
//   DATA_W / ADDR_W : byte-wide data path and 8-bit fetch/write addresses
//   IMEM_DEPTH      : number of instruction bytes held in memory
//   state_t         : loader FSM encoding
package cpu_pkg;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 8;
    localparam int IMEM_DEPTH = 256;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CHK  = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream handshake from the host link into the program loader.
//   in_data  : byte offered by the host
//   in_valid : in_data is valid
//   in_ready : loader accepts the byte (transfer when valid && ready on clk rise)
// Modports: master = host side, slave = loader side.
interface prog_loader_if;
    import cpu_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/imem_256x8.sv
// Instruction memory: one synchronous write port, one combinational read port.
// Contents are never reset. A read of the address being written shows the old
// value until the write edge.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : mem[raddr], zero latency
module imem_256x8
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [IMEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a length byte, then L payload bytes written to
// instruction memory from address 0, optionally followed by a checksum byte,
// and then releases the CPU from reset.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (adds CHK state, running
// sum and err reporting; without it err is tied to 0).
//   clk     : clock
//   reset   : asynchronous active-low reset
//   host    : byte-stream handshake (slave modport)
//   reload  : level request to abort/restart loading (wins over a transfer)
//   rd_addr : CPU fetch address
//   rd_data : instruction byte at rd_addr (combinational)
//   cpu_rst : holds the CPU in reset unless in RUN
//   done    : state is RUN
//   err     : state is ERR (checksum mismatch)
module prog_loader
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    prog_loader_if.slave      host,
    input  logic              reload,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] count;   // payload bytes accepted so far
    logic [ADDR_W-1:0] len;     // 0 encodes 256
    logic              xfer;
    logic              last;
    logic              we;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
`endif

    // Ready is decoded straight from state so reload blocks the byte in the
    // same cycle it is raised.
    assign host.in_ready = !reload &&
                           (state == ST_IDLE || state == ST_LOAD || state == ST_CHK);
    assign xfer = host.in_valid && host.in_ready;
    // 8-bit wrap makes len=0 terminate after the 256th byte.
    assign last = (count + 8'd1) == len;
    assign we   = xfer && (state == ST_LOAD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            addr  <= '0;
            count <= '0;
            len   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum   <= '0;
`endif
        end else if (reload) begin
            state <= ST_IDLE;
        end else if (xfer) begin
            case (state)
                ST_IDLE: begin
                    len   <= host.in_data;
                    addr  <= '0;
                    count <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum   <= '0;
`endif
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    addr  <= addr + 8'd1;
                    count <= count + 8'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum   <= sum + host.in_data;
                    if (last) state <= ST_CHK;
`else
                    if (last) state <= ST_RUN;
`endif
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    state <= (host.in_data == sum) ? ST_RUN : ST_ERR;
                end
`endif
                default: ;
            endcase
        end
    end

    assign cpu_rst = (state != ST_RUN);
    assign done    = (state == ST_RUN);
`ifdef PROG_LOADER_CHECKSUM_EN
    assign err     = (state == ST_ERR);
`else
    assign err     = 1'b0;
`endif

    imem_256x8 u_imem (
        .clk   (clk),
        .we    (we),
        .waddr (addr),
        .wdata (host.in_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader. Expected memory contents are pushed to
// a scoreboard queue as payload bytes are driven and popped when the loaded
// memory is read back through rd_addr/rd_data.
module tb_prog_loader;
    import cpu_pkg::*;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       reload = 1'b0;
    logic [7:0] rd_addr = 8'h00;
    logic [7:0] rd_data;
    logic       cpu_rst, done, err;

    prog_loader_if bus ();

    prog_loader dut (
        .clk     (clk),
        .reset   (reset),
        .host    (bus.slave),
        .reload  (reload),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .cpu_rst (cpu_rst),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int         n_pass = 0;
    int         n_total = 0;
    sb_t        sb_q[$];
    logic [7:0] model_mem [0:255];
    logic [7:0] tb_sum;

    task automatic send_byte(input logic [7:0] b, input int unsigned max_gap);
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        @(negedge clk);
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL send_ready got %b want 1", bus.in_ready);
        else n_pass++;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic start_load(input logic [7:0] len, input int unsigned gap);
        tb_sum = 8'h00;
        send_byte(len, gap);
    endtask

    task automatic payload(input logic [7:0] a, input logic [7:0] d, input int unsigned gap);
        model_mem[a] = d;
        sb_q.push_back('{a: a, d: d});
        tb_sum = tb_sum + d;
        send_byte(d, gap);
    endtask

    task automatic finish_load();
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(tb_sum, 0);
`endif
    endtask

    task automatic go_idle();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_total++; if (cpu_rst !== 1'b1) $display("FAIL rst_cpu_rst got %b want 1", cpu_rst); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", bus.in_ready); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_wrap256();
        go_idle();
        start_load(8'h00, 0);
        for (int i = 0; i < 256; i++) payload(i[7:0], i[7:0], 0);
        finish_load();
        n_total++; if (done !== 1'b1) $display("FAIL wrap_done got %b want 1", done); else n_pass++;
        n_total++; if (dut.addr !== 8'h00) $display("FAIL wrap_addr got %02h want 00", dut.addr); else n_pass++;
        while (sb_q.size() > 0) begin
            sb_t e;
            e = sb_q.pop_front();
            rd_addr = e.a;
            #1;
            n_total++;
            if (rd_data !== e.d) $display("FAIL wrap_mem[%02h] got %02h want %02h", e.a, rd_data, e.d);
            else n_pass++;
        end
    endtask

    task automatic test_load();
        go_idle();
        start_load(8'h03, 0);
        payload(8'h00, 8'h12, 0);
        payload(8'h01, 8'h34, 0);
        payload(8'h02, 8'h56, 0);
        finish_load();
        n_total++; if (done !== 1'b1) $display("FAIL load_done got %b want 1", done); else n_pass++;
        n_total++; if (cpu_rst !== 1'b0) $display("FAIL load_cpu_rst got %b want 0", cpu_rst); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL load_in_ready got %b want 0", bus.in_ready); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL load_err got %b want 0", err); else n_pass++;
        while (sb_q.size() > 0) begin
            sb_t e;
            e = sb_q.pop_front();
            rd_addr = e.a;
            #1;
            n_total++;
            if (rd_data !== e.d) $display("FAIL load_mem[%02h] got %02h want %02h", e.a, rd_data, e.d);
            else n_pass++;
        end
        // Bytes beyond the program length keep what the previous load wrote.
        rd_addr = 8'h03;
        #1;
        n_total++; if (rd_data !== 8'h03) $display("FAIL load_keep03 got %02h want 03", rd_data); else n_pass++;
        rd_addr = 8'hFF;
        #1;
        n_total++; if (rd_data !== 8'hFF) $display("FAIL load_keepFF got %02h want FF", rd_data); else n_pass++;
    endtask

    task automatic test_checksum_err();
`ifdef PROG_LOADER_CHECKSUM_EN
        go_idle();
        start_load(8'h03, 0);
        payload(8'h00, 8'h12, 0);
        payload(8'h01, 8'h34, 0);
        payload(8'h02, 8'h56, 0);
        send_byte(8'h00, 0);
        n_total++; if (err !== 1'b1) $display("FAIL chk_err got %b want 1", err); else n_pass++;
        n_total++; if (cpu_rst !== 1'b1) $display("FAIL chk_cpu_rst got %b want 1", cpu_rst); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL chk_in_ready got %b want 0", bus.in_ready); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL chk_done got %b want 0", done); else n_pass++;
        go_idle();
        n_total++; if (err !== 1'b0) $display("FAIL chk_reload_err got %b want 0", err); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL chk_reload_ready got %b want 1", bus.in_ready); else n_pass++;
        sb_q.delete();
`endif
    endtask

    task automatic test_reload();
        logic [7:0] keep1;
        go_idle();
        keep1 = model_mem[1];
        start_load(8'h03, 3);
        payload(8'h00, 8'hA1, 3);
        repeat ($urandom_range(3, 0)) @(negedge clk);
        @(negedge clk);
        bus.in_data  = 8'hB2;
        bus.in_valid = 1'b1;
        reload       = 1'b1;
        #1;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL rl_ready_low got %b want 0", bus.in_ready); else n_pass++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        reload       = 1'b0;
        #1;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rl_idle_ready got %b want 1", bus.in_ready); else n_pass++;
        n_total++; if (cpu_rst !== 1'b1) $display("FAIL rl_cpu_rst got %b want 1", cpu_rst); else n_pass++;
        rd_addr = 8'h01;
        #1;
        n_total++; if (rd_data !== keep1) $display("FAIL rl_dropped got %02h want %02h", rd_data, keep1); else n_pass++;
        while (sb_q.size() > 0) begin
            sb_t e;
            e = sb_q.pop_front();
            rd_addr = e.a;
            #1;
            n_total++;
            if (rd_data !== e.d) $display("FAIL rl_mem[%02h] got %02h want %02h", e.a, rd_data, e.d);
            else n_pass++;
        end
        start_load(8'h02, 2);
        payload(8'h00, 8'hC3, 2);
        payload(8'h01, 8'hD4, 2);
        finish_load();
        n_total++; if (done !== 1'b1) $display("FAIL rl_reload_done got %b want 1", done); else n_pass++;
        while (sb_q.size() > 0) begin
            sb_t e;
            e = sb_q.pop_front();
            rd_addr = e.a;
            #1;
            n_total++;
            if (rd_data !== e.d) $display("FAIL rl2_mem[%02h] got %02h want %02h", e.a, rd_data, e.d);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midload();
        go_idle();
        start_load(8'h03, 0);
        payload(8'h00, 8'h5A, 0);
        payload(8'h01, 8'h6B, 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_total++; if (cpu_rst !== 1'b1) $display("FAIL mr_cpu_rst got %b want 1", cpu_rst); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL mr_done got %b want 0", done); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL mr_err got %b want 0", err); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL mr_in_ready got %b want 1", bus.in_ready); else n_pass++;
        n_total++; if (dut.state !== ST_IDLE) $display("FAIL mr_state got %0d want %0d", dut.state, ST_IDLE); else n_pass++;
        n_total++; if (dut.count !== 8'h00) $display("FAIL mr_count got %02h want 00", dut.count); else n_pass++;
        n_total++; if (dut.addr !== 8'h00) $display("FAIL mr_addr got %02h want 00", dut.addr); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        while (sb_q.size() > 0) begin
            sb_t e;
            e = sb_q.pop_front();
            rd_addr = e.a;
            #1;
            n_total++;
            if (rd_data !== e.d) $display("FAIL mr_mem[%02h] got %02h want %02h", e.a, rd_data, e.d);
            else n_pass++;
        end
        rd_addr = 8'h02;
        #1;
        n_total++; if (rd_data !== model_mem[2]) $display("FAIL mr_keep02 got %02h want %02h", rd_data, model_mem[2]); else n_pass++;
    endtask

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        test_reset();
        test_wrap256();
        test_load();
        test_checksum_err();
        test_reload();
        test_reset_midload();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port in_data, input, 8: byte stream from host link.
REQ-004 SHALL have port in_valid, input, 1: in_data valid.
REQ-005 SHALL have port in_ready, output, 1: loader accepts byte; a transfer occurs on a clk edge with in_valid=1 and in_ready=1.
REQ-006 SHALL have port reload, input, 1: level request to abort or restart loading.
REQ-007 SHALL have port rd_addr, input, 8: CPU fetch address (PC).
REQ-008 SHALL have port rd_data, output, 8: instruction byte at rd_addr.
REQ-009 SHALL have port cpu_rst, output, 1: active-high hold-in-reset for the CPU core.
REQ-010 SHALL have ports done and err, output, 1 each: load complete; checksum failure.

Function
REQ-011 SHALL implement states IDLE, LOAD, CHK, RUN and ERR.
REQ-012 In IDLE, the first transferred byte SHALL be the length L, with L=0x00 meaning 256; the transfer SHALL clear the write address to 0 and move to LOAD.
REQ-013 In LOAD, each transfer SHALL write in_data to mem[addr] and increment addr mod 256.
REQ-014 On the L-th payload transfer, LOAD SHALL go to CHK if checksum is enabled, else to RUN.
REQ-015 In CHK, one transfer SHALL be compared with the 8-bit mod-256 sum of the payload: match goes to RUN, mismatch goes to ERR.
REQ-016 in_ready SHALL be 1 only in IDLE, LOAD or CHK, and only when reload=0; it SHALL be combinational from state and reload.
REQ-017 cpu_rst SHALL be 0 only in RUN, and SHALL fall the cycle after the final accepted byte.
REQ-018 done SHALL equal (state==RUN); err SHALL equal (state==ERR).
REQ-019 reload=1 in any state SHALL move to IDLE on the next edge and SHALL take priority over a simultaneous transfer; no write occurs and the byte is dropped.
REQ-020 rd_data SHALL be combinational mem[rd_addr] with zero latency; on a same-address write, the old value SHALL be shown until the write edge.
REQ-021 Addresses at or above L SHALL retain their previous contents.
REQ-022 Idle cycles with in_valid=0 SHALL NOT change state, addr or the running sum.

Reset
REQ-023 reset=0 SHALL immediately force the following: state=IDLE, addr=0, count=0, sum=0, cpu_rst=1, done=0, err=0, in_ready=1 (when reload=0).
REQ-024 Memory contents SHALL NOT be reset; an asserted reset mid-load SHALL abandon the load with partial contents kept.

Configuration
REQ-025 With PROG_LOADER_CHECKSUM_EN defined, the CHK state and the sum register SHALL exist and err is reachable.
REQ-026 Without PROG_LOADER_CHECKSUM_EN, LOAD SHALL go directly to RUN, and err SHALL be tied to 0.

Structure
REQ-027 Package cpu_pkg SHALL hold the state encoding, IMEM_DEPTH=256 and the 8-bit data/address width constants.
REQ-028 Storage SHALL be the sub-module imem_256x8: one synchronous write port and one combinational read port.
REQ-029 The FSM, counter and checksum logic SHALL reside in prog_loader.

Verification
REQ-030 Reset: reset=0 with reload=0 -> cpu_rst=1, in_ready=1, done=0, err=0 without waiting for a clock edge.
REQ-031 Load: bytes 0x03, 0x12, 0x34, 0x56, and 0x9C when the checksum is enabled -> done=1, cpu_rst=0 the next cycle; rd_addr=0x01 gives rd_data=0x34, and rd_addr=0x02 gives 0x56.
REQ-032 Length 0x00 plus 256 bytes, with data equal to the address -> mem[0xFF]=0xFF, addr wraps to 0, done=1.
REQ-033 With checksum enabled: 0x03, 0x12, 0x34, 0x56, then 0x00 -> err=1, cpu_rst=1, in_ready=0; then reload=1 for one cycle -> IDLE, err=0.
REQ-034 Random in_valid gaps, then reload during the edge of a second payload byte -> that byte is not written; the next load starts at address 0.
REQ-035 reset asserted after 2 of 3 payload bytes -> immediate reset outputs; mem[0..1] still hold the loaded bytes.
